// File: rtl/aludec_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : aludec_pipe
//  Brief    : MIPS ALU-control decoder with a single ready/valid output
//             register and a HI/LO occupancy tracker that stalls dependent
//             MULT/DIV/MFHI/MFLO/MTHI/MTLO instructions while busy.
//  Options  : ALUDEC_RI_EN - when defined, a registered reserved-instruction
//             flag (ri) is built; otherwise ri is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module aludec_pipe #(
  parameter int CTRL_W     = 8,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              md_busy,
  output logic              ri
);

  // Shared EXE_*_OP encodings
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b01011001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b01011010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b01011011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b00000100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b00000110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b00000111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b01010111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b01011000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_BEQ_OP   = 8'b01010001;
  localparam logic [7:0] EXE_LB_OP    = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP    = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP   = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP   = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP    = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP    = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP    = 8'b11101011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   alucontrol_q, alucontrol_d;
  logic [7:0]          dec_code;
  logic                is_mul, is_div, is_hilo, stall_hilo, accept;

  // Combinational opcode/funct decode; unknown encodings yield code 0
  always_comb begin
    dec_code = 8'h00;
    unique case (op)
      6'b000000: begin
        case (funct)
          6'b000000: dec_code = EXE_SLL_OP;
          6'b000010: dec_code = EXE_SRL_OP;
          6'b000011: dec_code = EXE_SRA_OP;
          6'b000100: dec_code = EXE_SLLV_OP;
          6'b000110: dec_code = EXE_SRLV_OP;
          6'b000111: dec_code = EXE_SRAV_OP;
          6'b010000: dec_code = EXE_MFHI_OP;
          6'b010001: dec_code = EXE_MTHI_OP;
          6'b010010: dec_code = EXE_MFLO_OP;
          6'b010011: dec_code = EXE_MTLO_OP;
          6'b011000: dec_code = EXE_MULT_OP;
          6'b011001: dec_code = EXE_MULTU_OP;
          6'b011010: dec_code = EXE_DIV_OP;
          6'b011011: dec_code = EXE_DIVU_OP;
          6'b100000: dec_code = EXE_ADD_OP;
          6'b100001: dec_code = EXE_ADDU_OP;
          6'b100010: dec_code = EXE_SUB_OP;
          6'b100011: dec_code = EXE_SUBU_OP;
          6'b100100: dec_code = EXE_AND_OP;
          6'b100101: dec_code = EXE_OR_OP;
          6'b100110: dec_code = EXE_XOR_OP;
          6'b100111: dec_code = EXE_NOR_OP;
          6'b101010: dec_code = EXE_SLT_OP;
          6'b101011: dec_code = EXE_SLTU_OP;
          default:   dec_code = 8'h00;
        endcase
      end
      6'b000100: dec_code = EXE_BEQ_OP;
      6'b001000: dec_code = EXE_ADDI_OP;
      6'b001001: dec_code = EXE_ADDIU_OP;
      6'b001010: dec_code = EXE_SLTI_OP;
      6'b001011: dec_code = EXE_SLTIU_OP;
      6'b001100: dec_code = EXE_ANDI_OP;
      6'b001101: dec_code = EXE_ORI_OP;
      6'b001110: dec_code = EXE_XORI_OP;
      6'b001111: dec_code = EXE_LUI_OP;
      6'b100000: dec_code = EXE_LB_OP;
      6'b100001: dec_code = EXE_LH_OP;
      6'b100011: dec_code = EXE_LW_OP;
      6'b100100: dec_code = EXE_LBU_OP;
      6'b100101: dec_code = EXE_LHU_OP;
      6'b101000: dec_code = EXE_SB_OP;
      6'b101001: dec_code = EXE_SH_OP;
      6'b101011: dec_code = EXE_SW_OP;
      default:   dec_code = 8'h00;
    endcase
  end

  // HI/LO hazard classification and handshake; flush blocks any accept
  always_comb begin
    is_mul     = (op == 6'b000000) && (funct inside {6'b011000, 6'b011001});
    is_div     = (op == 6'b000000) && (funct inside {6'b011010, 6'b011011});
    is_hilo    = (op == 6'b000000) &&
                 (funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                                6'b010000, 6'b010001, 6'b010010, 6'b010011});
    stall_hilo = md_busy && is_hilo;
    in_ready   = (!out_valid_q || out_ready) && !stall_hilo && !flush;
    accept     = in_valid && in_ready;
  end

  // Output stage next-state: flush wins, then load, then drain on consume
  always_comb begin
    out_valid_d  = out_valid_q;
    alucontrol_d = alucontrol_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      alucontrol_d = CTRL_W'(dec_code);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // HI/LO occupancy FSM next-state; flush has no effect here
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d = ST_BUSY;
          cnt_d   = 8'(MUL_CYCLES);
        end else if (accept && is_div) begin
          state_d = ST_BUSY;
          cnt_d   = 8'(DIV_CYCLES);
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 8'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      out_valid_q  <= 1'b0;
      alucontrol_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      alucontrol_q <= alucontrol_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alucontrol = alucontrol_q;
  assign md_busy    = (state_q == ST_BUSY);

`ifdef ALUDEC_RI_EN
  logic ri_q, ri_d;

  // Reserved-instruction flag travels with alucontrol; every legal code is non-zero
  always_comb begin
    ri_d = ri_q;
    if (!flush && accept) ri_d = (dec_code == 8'h00);
  end

  // Registered ri flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ri_q <= 1'b0;
    else         ri_q <= ri_d;
  end

  assign ri = ri_q;
`else
  assign ri = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/aludec_pipe.md
ALUDEC_PIPE -- requirements
Module: aludec_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 8: width of alucontrol; codes are the shared EXE_*_OP values in defines.vh, zero-extended or truncated to CTRL_W.
REQ-002 SHALL have parameter MUL_CYCLES, default 2, legal 1..255: HI/LO occupancy after MULT/MULTU.
REQ-003 SHALL have parameter DIV_CYCLES, default 32, legal 1..255: HI/LO occupancy after DIV/DIVU.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  upstream presents op/funct.
REQ-007 in_ready  out  1  block accepts this cycle.
REQ-008 op  in  6  instruction opcode.
REQ-009 funct  in  6  instruction funct (used when op==6'b000000).
REQ-010 flush  in  1  discard output-stage contents.
REQ-011 out_valid  out  1  alucontrol valid.
REQ-012 out_ready  in  1  downstream consumes this cycle.
REQ-013 alucontrol  out  CTRL_W  decoded ALU operation.
REQ-014 md_busy  out  1  HI/LO unit occupied.
REQ-015 ri  out  1  reserved-instruction flag, qualified by out_valid.

Function
REQ-016 SHALL decode every R-type arithmetic, logic and shift funct, loads, stores, BEQ, ADDI/ADDIU/SLTI/SLTIU, ANDI/ORI/XORI/LUI to its EXE_*_OP code (LW/SW/ADDI/BEQ-style mapping unchanged from current decode), plus MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO to their EXE_*_OP codes.
REQ-017 Unrecognised op or funct SHALL decode to alucontrol 0.
REQ-018 Output stage SHALL be one register: accept (in_valid && in_ready) in cycle N -> out_valid, alucontrol in cycle N+1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !stall_hilo, combinationally.
REQ-020 stall_hilo SHALL be md_busy && incoming funct in {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO} with op==0; other instructions SHALL pass while busy.
REQ-021 out_valid && !out_ready SHALL hold alucontrol and ri stable.
REQ-022 out_valid && out_ready with no new accept SHALL clear out_valid next cycle; simultaneous consume and accept SHALL load the new entry (full throughput).
REQ-023 FSM states IDLE, BUSY; counter cnt of 8 bits.
REQ-024 IDLE -> BUSY on accepting MULT/MULTU (cnt<=MUL_CYCLES) or DIV/DIVU (cnt<=DIV_CYCLES).
REQ-025 BUSY: cnt decrements each cycle; at cnt==1 -> IDLE with cnt 0; md_busy = (state==BUSY).
REQ-026 Dependent instruction stalled in last BUSY cycle SHALL be accepted the cycle state returns to IDLE (no extra bubble beyond cnt).
REQ-027 flush SHALL clear out_valid next cycle and take priority over a same-cycle accept (accept discarded, in_ready forced 0); flush SHALL NOT alter FSM or cnt.

Reset
REQ-028 resetn low SHALL asynchronously force out_valid 0, alucontrol 0, ri 0, state IDLE, cnt 0, md_busy 0.
REQ-029 Reset mid-BUSY SHALL abandon the operation; first cycle after release in_ready 1.

Configuration
REQ-030 Macro ALUDEC_RI_EN defined: ri SHALL be registered with alucontrol, 1 for unrecognised op or R-type funct, else 0.
REQ-031 ALUDEC_RI_EN undefined: ri SHALL be constant 0 and no ri logic built; decode otherwise identical.

Verification
REQ-032 op 0, funct 6'b100000, in_valid 1, out_ready 1 -> next cycle out_valid 1, alucontrol EXE_ADD_OP (8'b00100000), ri 0.
REQ-033 DIV (funct 6'b011010) accepted at cycle 0, MFLO (6'b010010) presented cycle 1 -> in_ready 0 cycles 1..32, MFLO accepted cycle 33, md_busy falls cycle 33.
REQ-034 DIV accepted cycle 0, ADD presented cycle 1 -> ADD accepted cycle 1, out_valid with EXE_ADD_OP cycle 2, md_busy still 1.
REQ-035 out_ready 0 for 5 cycles with out_valid 1 (ORI) -> alucontrol EXE_ORI_OP stable, in_ready 0; out_ready 1 -> next accept loads.
REQ-036 MULT accepted, resetn pulsed low cycle 1 -> md_busy 0, out_valid 0 immediately; MFHI accepted first cycle after release.
REQ-037 ALUDEC_RI_EN defined, op 6'b111111 -> out_valid 1, alucontrol 0, ri 1; undefined -> ri 0.
